// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit and its lane-alignment helper.
//   - access size encodings (byte / half / word / reserved)
//   - FSM state encoding
//   - default word-address width of the attached data memory
//   - req_bad(): misalignment / reserved-size classification
package mem_pkg;

  localparam int ADDR_W_DEF = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  // 1 when the request must be answered with an error and no memory access.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane helper for the load/store unit.
//   i_word   : word read from memory (little-endian lanes)
//   i_off    : byte offset within the word
//   i_size   : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_signed : sign-extend sub-word loads
//   i_new    : right-aligned store data; bits above the size are ignored
//   o_load   : extracted and extended load value
//   o_merged : i_word with the addressed lanes replaced by i_new
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_new,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_sh;
  logic [31:0] w_shift;
  logic [31:0] w_mask;

  assign w_sh    = {i_off, 3'b000};
  assign w_shift = i_word >> w_sh;

  always_comb begin
    o_load = w_shift;
    w_mask = 32'hFFFF_FFFF;
    case (i_size)
      SZ_BYTE: begin
        w_mask = 32'h0000_00FF;
        o_load = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
      end
      SZ_HALF: begin
        w_mask = 32'h0000_FFFF;
        o_load = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
      end
      default: begin
        w_mask = 32'hFFFF_FFFF;
        o_load = w_shift;
      end
    endcase
  end

  assign o_merged = (i_word & ~(w_mask << w_sh)) | ((i_new & w_mask) << w_sh);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-addressed data memory.
// Byte-addressed byte/half/word requests arrive over valid/ready; sub-word
// stores are done as read-modify-write. One request in flight at a time.
//   clk, rst                 : clock, async active-high reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_write/size/signed    : request kind
//   req_addr, req_wdata      : byte address, right-aligned store data
//   resp_valid/rdata/err     : one-cycle completion pulse with load data / error
//   mem_*                    : data memory port (combinational read data)
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_t        r_state;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;   // store data until RD, then the merged word
  logic              r_memwrite;
  logic              r_memread;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;

  assign req_ready      = (r_state == ST_IDLE) && !rst;
  assign resp_valid     = r_resp_valid;
  assign resp_rdata     = r_resp_rdata;
  assign resp_err       = r_resp_err;
  assign mem_address    = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign mem_memwrite   = r_memwrite;
  assign mem_memread    = r_memread;

  lsu_lane_align u_align (
    .i_word   (mem_read_data),
    .i_off    (r_off),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_new    (r_mem_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_off        <= 2'b00;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_memwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_off    <= req_addr[1:0];
            if (req_bad(req_size, req_addr[1:0])) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_mem_addr <= req_addr[ADDR_W+1:2];
              if (req_write) r_mem_wdata <= req_wdata;
              // Full-word stores skip the read; everything else reads first.
              if (req_write && req_size == SZ_WORD) begin
                r_state    <= ST_WR;
                r_memwrite <= 1'b1;
              end else begin
                r_state   <= ST_RD;
                r_memread <= 1'b1;
              end
            end
          end
        end
        ST_RD: begin
          r_memread <= 1'b0;
          if (r_write) begin
            r_mem_wdata <= w_merged;
            r_memwrite  <= 1'b1;
            r_state     <= ST_WR;
          end else begin
            r_resp_rdata <= w_load;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_WR: begin
          r_memwrite   <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [4:0]  mem_address;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data;

  load_store_unit #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] wmem [32];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) wmem[i] <= $urandom;
      mem_init <= 1'b1;
    end else if (mem_memwrite) begin
      wmem[mem_address] <= mem_write_data;
    end
  end
  assign mem_read_data = wmem[mem_address];

  // Reference: byte-addressed memory image plus a queue of expected responses.
  typedef struct {
    int          acc;
    logic [4:0]  waddr;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wword;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  logic [7:0]  bm [128];
  exp_t        q [$];
  exp_t        me;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  int          n_resp   = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input bit w, input logic [1:0] sz, input bit sg,
                              input logic [6:0] a, input logic [31:0] wd);
    exp_t e;
    int n;
    logic [31:0] v, m;
    e.acc = cyc; e.waddr = a[6:2]; e.err = 1'b0; e.rdata = 0; e.wword = 0;
    e.lat = 0; e.nrd = 0; e.nwr = 0;
    n = 1 << sz;
    if (sz == 2'd3 || (a % n) != 0) begin
      e.err = 1'b1; e.lat = 1;
    end else if (!w) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(bm[int'(a) + i]) << (8 * i));
      if (sg && n < 4) begin
        m = (32'd1 << (8 * n)) - 32'd1;
        if (v[8 * n - 1]) v = v | ~m;
      end
      e.rdata = v; e.lat = 2; e.nrd = 1;
    end else begin
      for (int i = 0; i < n; i++) bm[int'(a) + i] = wd[8 * i +: 8];
      for (int i = 0; i < 4; i++) e.wword[8 * i +: 8] = bm[int'(e.waddr) * 4 + i];
      e.nwr = 1;
      e.nrd = (n < 4) ? 1 : 0;
      e.lat = (n < 4) ? 3 : 2;
    end
    q.push_back(e);
  endtask

  // Leaves req_valid high; caller decides whether to drop it.
  task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                        input logic [6:0] a, input logic [31:0] wd,
                        input bit drop, output int waits);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    waits = 0;
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
      return;
    end
    @(posedge clk);
    #1;
    if (!drop) model_accept(w, sz, sg, a, wd);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", q.size());
    end
  endtask

  task automatic req1(input bit w, input logic [1:0] sz, input bit sg,
                      input logic [6:0] a, input logic [31:0] wd);
    int wt;
    do_req(w, sz, sg, a, wd, 1'b0, wt);
    req_valid = 1'b0;
    wait_done();
  endtask

  // Per-cycle compare against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_memread && mem_memwrite) chk("rd_wr_overlap", 32'(mem_memwrite), 32'd0);
      if (q.size() == 0) begin
        if (resp_valid || mem_memwrite || mem_memread)
          chk("spurious_activity", {29'd0, resp_valid, mem_memwrite, mem_memread}, 32'd0);
      end else begin
        me = q[0];
        if (mem_memread) begin
          rd_cnt++;
          chk("rd_addr", 32'(mem_address), 32'(me.waddr));
        end
        if (mem_memwrite) begin
          wr_cnt++;
          chk("wr_addr", 32'(mem_address), 32'(me.waddr));
          chk("wr_data", mem_write_data, me.wword);
        end
        if (resp_valid) begin
          chk("resp_rdata", resp_rdata, me.rdata);
          chk("resp_err", 32'(resp_err), 32'(me.err));
          chk("latency", 32'(cyc - me.acc + 1), 32'(me.lat));
          chk("memread_cycles", 32'(rd_cnt), 32'(me.nrd));
          chk("memwrite_cycles", 32'(wr_cnt), 32'(me.nwr));
          last_rdata = resp_rdata;
          last_err   = resp_err;
          last_lat   = cyc - me.acc + 1;
          void'(q.pop_front());
          rd_cnt = 0;
          wr_cnt = 0;
          n_resp++;
        end
      end
    end
  end

  initial begin
    int w0, w1;
    logic [1:0] sz;
    logic [6:0] a;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;
    for (int wi = 0; wi < 32; wi++)
      for (int b = 0; b < 4; b++) bm[wi * 4 + b] = wmem[wi][8 * b +: 8];
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_ctl", {30'd0, mem_memwrite, mem_memread}, 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Directed sequence with literal expectations.
    req1(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF);
    chk("wst_lat", 32'(last_lat), 32'd2);
    chk("wst_mem", wmem[2], 32'hDEADBEEF);
    req1(1'b0, 2'b00, 1'b1, 7'h0B, 32'h0);
    chk("lb_signed", last_rdata, 32'hFFFFFFDE);
    chk("lb_lat", 32'(last_lat), 32'd2);
    req1(1'b0, 2'b00, 1'b0, 7'h0B, 32'h0);
    chk("lbu", last_rdata, 32'h000000DE);
    req1(1'b0, 2'b01, 1'b1, 7'h0A, 32'h0);
    chk("lh_signed", last_rdata, 32'hFFFFDEAD);
    req1(1'b1, 2'b00, 1'b0, 7'h09, 32'hABCDEF55);
    chk("sb_lat", 32'(last_lat), 32'd3);
    chk("sb_mem", wmem[2], 32'hDEAD55EF);
    req1(1'b0, 2'b10, 1'b0, 7'h08, 32'h0);
    chk("lw_after_sb", last_rdata, 32'hDEAD55EF);
    req1(1'b0, 2'b10, 1'b0, 7'h06, 32'h0);
    chk("lw_mis_err", 32'(last_err), 32'd1);
    chk("lw_mis_lat", 32'(last_lat), 32'd1);
    req1(1'b1, 2'b01, 1'b0, 7'h03, 32'h1234);
    chk("sh_mis_err", 32'(last_err), 32'd1);
    chk("sh_mis_rdata", last_rdata, 32'd0);

    // Back-to-back: valid held; second request waits through RD and RESP.
    do_req(1'b0, 2'b10, 1'b0, 7'h08, 32'h0, 1'b0, w0);
    do_req(1'b1, 2'b01, 1'b0, 7'h04, 32'h00C0FFEE, 1'b0, w1);
    req_valid = 1'b0;
    chk("b2b_wait_cycles", 32'(w1), 32'd2);
    wait_done();
    req1(1'b0, 2'b10, 1'b0, 7'h04, 32'h0);
    chk("b2b_store_data", last_rdata & 32'h0000FFFF, 32'h0000FFEE);

    // Reset during RD of a sub-word store: dropped with no write or response.
    do_req(1'b1, 2'b00, 1'b0, 7'h0A, 32'h77, 1'b1, w0);
    req_valid = 1'b0;
    rst = 1'b1;
    q.delete(); rd_cnt = 0; wr_cnt = 0;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_outs", {28'd0, resp_valid, resp_err, mem_memwrite, mem_memread}, 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    chk("midrst_addr", 32'(mem_address), 32'd0);
    chk("midrst_wdata", mem_write_data, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("midrst_mem_unchanged", wmem[2], 32'hDEAD55EF);
    req1(1'b0, 2'b10, 1'b0, 7'h08, 32'h0);
    chk("after_rst_load", last_rdata, 32'hDEAD55EF);

    // Randomized traffic, sometimes back-to-back, sometimes with idle gaps.
    for (int it = 0; it < 400; it++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~7'((1 << sz) - 1);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, w0);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    wait_done();
    for (int wi = 0; wi < 32; wi++)
      chk("final_mem", wmem[wi], {bm[wi*4+3], bm[wi*4+2], bm[wi*4+1], bm[wi*4]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
